product_accumulator: RTL
========================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit combinational multiplier; consumes its 8-bit product.
- Sums a fixed block of COUNT products and presents the sum with a valid/ready handshake.
- Flags arithmetic overflow of the accumulator.
- Forms the accumulate half of the team's multiply-accumulate (MAC) datapath.

Parameters:
- COUNT, 4, products summed per block (legal range 1..255).
- ACC_W, 12, accumulator/result width in bits (legal range 8..32). Default covers 4 x 225 = 900.

Ports:
- clk  input  1  single rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous flush; discards any partial or held block
- in_valid  input  1  product beat offered
- in_ready  output  1  block can accept a beat
- product  input  8  unsigned product from the multiplier
- out_valid  output  1  block sum available
- out_ready  input  1  downstream accepts the sum
- out_data  output  ACC_W  accumulated sum (unsigned, modulo 2^ACC_W)
- overflow  output  1  the block's true sum exceeded 2^ACC_W - 1
- beat_count  output  8  beats accepted in the current block

Behaviour:
- Reset (async, immediate on rst high): state=IDLE, acc=0, beat_count=0, overflow=0, out_valid=0, out_data=0, in_ready=1.
- Accept occurs on a clock edge where in_valid && in_ready. Reject (no effect) otherwise. in_valid may gap arbitrarily.
- States:
  - IDLE: acc=0, in_ready=1. An accepted beat sets acc=product and beat_count=1. Next state is DONE if COUNT==1, else ACCUM.
  - ACCUM: in_ready=1. An accepted beat sets acc=acc+product and increments beat_count. On the COUNT-th beat, go to DONE.
  - DONE: in_ready=0, out_valid=1. out_data and overflow are held stable. On out_ready, go to IDLE with acc=0, beat_count=0, overflow=0.
- Latency: out_valid rises the cycle after the COUNT-th accept.
- Throughput: one block per COUNT+1 cycles minimum, since DONE blocks input. The next block may start the cycle after the out handshake.
- Arithmetic: the sum is computed at ACC_W+1 bits. The carry-out sets overflow (sticky within the block). acc keeps the low ACC_W bits (wraps).
- out_data is registered and equals acc. It is valid only while out_valid is high; otherwise it is held at its last value.
- clear (synchronous) has priority over any beat and any out handshake in the same cycle. The next state is IDLE with acc=0, beat_count=0, overflow=0, out_valid=0. A beat presented with clear is dropped.
- clear in DONE discards the result without an out handshake.
- rst mid-block or in DONE: immediate return to reset values; no result is emitted.
- out_ready while not in DONE is ignored.
- Values are never updated with out_valid high and out_ready low (stable under backpressure).

Decomposition:
- Shared package/header holds:
  - State encodings IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - Default COUNT and ACC_W localparams, reused by the future MAC top.
- No sub-module needed. The FSM, beat counter and adder stay in a single module.
- The multiplier is instantiated only at MAC top level, not inside this block.

Test Plan:
- Basic block: products 6, 35, 225, 32 on consecutive cycles, out_ready=1 -> out_valid one cycle after beat 4, out_data=298 (0x12A), overflow=0, then in_ready=1 the following cycle.
- Gapped input: same four products with in_valid low for 2 cycles between each -> out_data=298, beat_count steps 1..4, no extra accepts.
- Backpressure: complete the block, hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data=298 stable, no beats accepted, release -> IDLE.
- Overflow: bench instance ACC_W=9, four beats of 225 -> out_data=388 (900 mod 512), overflow=1; next block 1, 1, 1, 1 -> out_data=4, overflow=0.
- Clear mid-block: accept 225, 225, then assert clear together with product 100 -> beat dropped, beat_count=0. Then 1, 2, 3, 4 -> out_data=10.
- Async reset: assert rst between clock edges during ACCUM (beat_count=2) and during DONE -> outputs go to reset values before the next edge. After release, a fresh block 3, 3, 3, 3 -> out_data=12.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the accumulate half of the MAC datapath.
// The state encoding and default sizing are reused by the MAC top.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_t;

  localparam int unsigned DefaultCount = 4;
  localparam int unsigned DefaultAccW  = 12;

endpackage

// File: rtl/product_accumulator.sv
// Sums blocks of COUNT 8-bit products and offers each block sum on a valid/ready port.
// The overflow flag is sticky within a block; the accumulator wraps modulo 2^ACC_W.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned COUNT = DefaultCount,
  parameter int unsigned ACC_W = DefaultAccW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             overflow,
  output logic [7:0]       beat_count
);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W:0]   sum;
  logic             last_beat;

  assign in_ready   = (state_q != StDone);
  assign out_valid  = (state_q == StDone);
  assign out_data   = data_q;
  assign overflow   = ovf_q;
  assign beat_count = cnt_q;

  // acc is zero in idle, so the first beat loads the product through the same adder.
  assign sum       = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, product};
  assign last_beat = (cnt_q == 8'(COUNT - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle, StAccum: begin
          if (in_valid) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
            cnt_d = cnt_q + 8'd1;
            if (last_beat) begin
              state_d = StDone;
              data_d  = sum[ACC_W-1:0];
            end else begin
              state_d = StAccum;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
